// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/note-off events onto NUM_VOICES envelope voices (gate + note).
// Latency: note-on to gate high is 2 clk; a retrigger/steal holds the gate low RETRIG_CYCLES+1 cycles.
// Backpressure: ev_ready only in IDLE outside rst/panic; note-offs are accepted back-to-back.
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int NOTE_W        = 7,
  parameter int RETRIG_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic                         panic,
  input  logic [NUM_VOICES-1:0]        voice_idle,
  output logic [NUM_VOICES-1:0]        gate,
  output logic [NUM_VOICES*NOTE_W-1:0] note,
  output logic                         stolen
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW = $clog2(RETRIG_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_RETRIG} state_t;

  state_t                state_q, state_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [VW-1:0]         age_q  [NUM_VOICES];
  logic [VW-1:0]         age_d  [NUM_VOICES];
  logic [NOTE_W-1:0]     lat_q, lat_d;
  logic [VW-1:0]         tgt_q, tgt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  stolen_q, stolen_d;

  logic                  found_a, found_b, found_c;
  logic [VW-1:0]         idx_a, idx_b, idx_c, idx_d;
  logic [VW-1:0]         pick;
  logic                  pick_steal;
  logic                  do_age;
  logic [VW-1:0]         age_v;

  assign ev_ready = (state_q == S_IDLE) & ~rst & ~panic;
  assign gate     = gate_q;
  assign stolen   = stolen_q;

  // Flatten per-voice notes onto the output bus, voice i at [i*NOTE_W +: NOTE_W].
  always_comb begin
    note = '0;
    for (int i = 0; i < NUM_VOICES; i++) note[i*NOTE_W +: NOTE_W] = note_q[i];
  end

  // Target selection: held note, then idle released voice, then oldest released, then oldest overall.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    found_c = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    idx_c   = '0;
    idx_d   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found_a && gate_q[i] && (note_q[i] == lat_q)) begin
        found_a = 1'b1;
        idx_a   = VW'(i);
      end
      if (!found_b && !gate_q[i] && voice_idle[i]) begin
        found_b = 1'b1;
        idx_b   = VW'(i);
      end
      if (!gate_q[i] && (!found_c || (age_q[i] > age_q[idx_c]))) begin
        found_c = 1'b1;
        idx_c   = VW'(i);
      end
      if (age_q[i] > age_q[idx_d]) idx_d = VW'(i);
    end
    pick_steal = 1'b0;
    if (found_a)      pick = idx_a;
    else if (found_b) pick = idx_b;
    else if (found_c) pick = idx_c;
    else begin
      pick       = idx_d;
      pick_steal = 1'b1;
    end
  end

  // Next-state logic; panic overrides everything and aborts any allocation in flight.
  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    note_d   = note_q;
    age_d    = age_q;
    lat_d    = lat_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    stolen_d = 1'b0;
    do_age   = 1'b0;
    age_v    = tgt_q;
    if (panic) begin
      gate_d  = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev_valid && ev_ready) begin
            if (ev_on) begin
              lat_d   = ev_note;
              state_d = S_DECIDE;
            end else begin
              for (int i = 0; i < NUM_VOICES; i++)
                if (gate_q[i] && (note_q[i] == ev_note)) gate_d[i] = 1'b0;
            end
          end
        end
        S_DECIDE: begin
          tgt_d        = pick;
          note_d[pick] = lat_q;
          if (gate_q[pick]) begin
            // Counter starts at RETRIG_CYCLES and the gate rises on the edge leaving 0,
            // giving RETRIG_CYCLES+1 low cycles after this edge.
            gate_d[pick] = 1'b0;
            cnt_d        = CW'(RETRIG_CYCLES);
            stolen_d     = pick_steal;
            state_d      = S_RETRIG;
          end else begin
            gate_d[pick] = 1'b1;
            do_age       = 1'b1;
            age_v        = pick;
            state_d      = S_IDLE;
          end
        end
        S_RETRIG: begin
          if (cnt_q == '0) begin
            gate_d[tgt_q] = 1'b1;
            do_age        = 1'b1;
            age_v         = tgt_q;
            state_d       = S_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (do_age) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (age_q[i] < age_q[age_v]) age_d[i] = age_q[i] + VW'(1);
      age_d[age_v] = '0;
    end
  end

  // State registers; ages reset to a distinct 0..N-1 ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gate_q   <= '0;
      lat_q    <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      stolen_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= VW'(i);
      end
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      note_q   <= note_d;
      age_q    <= age_d;
      lat_q    <= lat_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      stolen_q <= stolen_d;
    end
  end

endmodule
